// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory responder: FSM state encoding and
// default datapath sizes used by both the cache datapath and the memory model.
package mem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_WPB    = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_RBURST = 3'd2,
    ST_WBURST = 3'd3,
    ST_DONE   = 3'd4
  } mem_state_e;

endpackage

// File: rtl/main_mem_ctrl_if.sv
// Cache-to-memory block transfer bus: level-held requests, word-serial bursts,
// four-phase done handshake.
//
// Handshake: the master raises mem_read or mem_write (with mem_addr) and holds
// it until done=1; the slave serves the block, raises done and keeps it until
// both requests are low. Burst beats carry no backpressure: a beat moves on
// every cycle rvalid=1 (slave->master) or wready=1 (master->slave).
interface main_mem_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              wready;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output mem_read, mem_write, mem_addr, wdata,
    input  rdata, rvalid, wready, busy, done, err
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, wdata,
    output rdata, rvalid, wready, busy, done, err
  );
endinterface

// File: rtl/mem_array.sv
// Backing store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module mem_array #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/main_mem_ctrl.sv
// Memory-side responder for block fills and writebacks with configurable
// access latency and one-block word-serial bursts.
module main_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int WPB        = DEF_WPB,
  parameter int LATENCY    = 3,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic           clk,
  input  logic           rst_b,
  main_mem_ctrl_if.slave bus,
  output mem_state_e     dbg_state
);

  localparam int BEAT_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W  = DEPTH_LOG2 + $clog2(WPB);

  mem_state_e            state_q, state_d;
  logic [DEPTH_LOG2-1:0] blk_q, blk_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  is_wr_q, is_wr_d;
  logic                  err_q, err_d;

  logic [ADDR_W-1:0] addr_in;
  logic              req;
  logic              we;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] arr_rdata;

  assign addr_in = bus.mem_addr;
  assign req     = bus.mem_read | bus.mem_write;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      is_wr_q <= is_wr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    is_wr_d = is_wr_q;
    err_d   = 1'b0;
    we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          // Upper address bits are dropped: blocks alias modulo the depth.
          blk_d   = DEPTH_LOG2'(addr_in);
          is_wr_d = bus.mem_write;
          err_d   = bus.mem_read & bus.mem_write;
          beat_d  = '0;
          if (LATENCY == 0) begin
            state_d = bus.mem_write ? ST_WBURST : ST_RBURST;
          end else begin
            lat_d   = LAT_W'(LATENCY - 1);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) state_d = is_wr_q ? ST_WBURST : ST_RBURST;
        else             lat_d   = lat_q - 1'b1;
      end
      ST_RBURST, ST_WBURST: begin
        we     = (state_q == ST_WBURST);
        beat_d = beat_q + 1'b1;
        if (beat_q == BEAT_W'(WPB - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Word index is {block, beat}; the beat never carries into the block field.
  if (WPB > 1) begin : g_idx_burst
    assign idx = {blk_q, beat_q};
  end else begin : g_idx_single
    assign idx = blk_q;
  end

  mem_array #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .idx   (idx),
    .wdata (bus.wdata),
    .rdata (arr_rdata)
  );

  assign bus.rvalid = (state_q == ST_RBURST);
  assign bus.wready = (state_q == ST_WBURST);
  assign bus.busy   = (state_q == ST_WAIT) || (state_q == ST_RBURST) ||
                      (state_q == ST_WBURST);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.err    = err_q;
  assign bus.rdata  = bus.rvalid ? arr_rdata : '0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Bench for main_mem_ctrl: directed scenarios plus randomized block transfers
// checked against a word-array reference of the backing store.
module tb_main_mem_ctrl;
  import mem_pkg::*;

  localparam int LAT  = 3;
  localparam int WPB  = 4;
  localparam int DEP  = 256;

  logic clk;
  logic rst_b;
  mem_state_e dbg_state;

  main_mem_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  main_mem_ctrl #(
    .ADDR_W     (16),
    .DATA_W     (32),
    .WPB        (WPB),
    .LATENCY    (LAT),
    .DEPTH_LOG2 (8)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ref_mem [DEP*WPB];
  bit          known   [DEP*WPB];
  int          wr_blks [$];
  logic [31:0] exp_q [$];

  logic [4:0] status;
  assign status = {bus.busy, bus.rvalid, bus.wready, bus.done, bus.err};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One complete transaction as seen by the requester. Cycle n counts negedges
  // after the request is presented: WAIT for n in 1..LAT, beat n-LAT-1 after.
  task automatic run_txn(input logic wr, input logic rd, input logic [15:0] addr,
                         input logic [3:0][31:0] wd, input int hold, input int rst_beat);
    int blk;
    int b;
    logic [4:0] exp_st;
    blk = int'(addr) % DEP;
    @(negedge clk);
    bus.mem_write = wr;
    bus.mem_read  = rd;
    bus.mem_addr  = addr;
    if (!wr) begin
      for (int k = 0; k < WPB; k++) exp_q.push_back(ref_mem[blk*WPB+k]);
    end
    for (int n = 1; n <= LAT + WPB; n++) begin
      @(negedge clk);
      bus.mem_addr = 16'($urandom);
      b = n - LAT - 1;
      if (wr && b == rst_beat) begin
        rst_b = 1'b0;
        #1;
        check_val("rst_mid_status", 32'(status), 32'd0);
        check_val("rst_mid_rdata", bus.rdata, 32'd0);
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        return;
      end
      exp_st = {1'b1, (!wr && b >= 0), (wr && b >= 0), 1'b0, (wr && rd && n == 1)};
      check_val("burst_status", 32'(status), 32'(exp_st));
      if (b >= 0) begin
        if (wr) begin
          bus.wdata = wd[b];
          ref_mem[blk*WPB+b] = wd[b];
          known[blk*WPB+b]   = 1'b1;
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (known[blk*WPB+b]) check_val("rdata", bus.rdata, e);
        end
      end
    end
    if (wr && !wr_blks.size() && 0) wr_blks.push_back(blk);
    if (wr) wr_blks.push_back(blk);
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      check_val("done_hold", 32'(status), 32'b00010);
    end
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    @(negedge clk);
    check_val("idle_after_done", 32'(status), 32'd0);
  endtask

  function automatic logic [3:0][31:0] seq(input logic [31:0] base);
    logic [3:0][31:0] r;
    for (int k = 0; k < 4; k++) r[k] = base + 32'(k);
    return r;
  endfunction

  initial begin
    logic [3:0][31:0] none;
    none = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.wdata     = '0;
    rst_b         = 1'b0;

    // reset
    repeat (2) @(negedge clk);
    check_val("reset_status", 32'(status), 32'd0);
    check_val("reset_rdata", bus.rdata, 32'd0);
    check_val("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("idle_no_req", 32'(status), 32'd0);
    end

    // write then read
    run_txn(1'b1, 1'b0, 16'd5, seq(32'hA0), 0, -1);
    run_txn(1'b0, 1'b1, 16'd5, none, 0, -1);
    // simultaneous requests: write wins, err pulses
    run_txn(1'b1, 1'b1, 16'd7, seq(32'hB0), 0, -1);
    run_txn(1'b0, 1'b1, 16'd7, none, 0, -1);
    // long hold past done, then re-raise
    run_txn(1'b0, 1'b1, 16'd5, none, 5, -1);
    run_txn(1'b0, 1'b1, 16'd7, none, 0, -1);
    // aliasing
    run_txn(1'b1, 1'b0, 16'h0101, seq(32'hC0), 0, -1);
    run_txn(1'b0, 1'b1, 16'h0001, none, 0, -1);
    // reset mid write burst: only the first two beats land
    run_txn(1'b1, 1'b0, 16'd9, seq(32'h10), 0, -1);
    run_txn(1'b1, 1'b0, 16'd9, seq(32'hD0), 0, 2);
    check_val("rst_mid_idle", 32'(status), 32'd0);
    run_txn(1'b0, 1'b1, 16'd9, none, 0, -1);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      logic [3:0][31:0] d;
      logic [15:0] a;
      for (int k = 0; k < 4; k++) d[k] = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        a = 16'($urandom);
        run_txn(1'b1, ($urandom_range(0, 3) == 0), a, d, $urandom_range(0, 3), -1);
      end else begin
        a = {8'($urandom), 8'(wr_blks[$urandom_range(0, wr_blks.size() - 1)])};
        run_txn(1'b0, 1'b1, a, none, $urandom_range(0, 3), -1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
